// File: rtl/riscv_lsu.sv
// Load/store unit between the core datapath and a single-port data memory.
// Two-state handshake FSM; byte lanes, store replication and load extension are combinational.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_mem_req;
  logic        w_stall;

  function automatic logic [3:0] f_store_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] f_store_data(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{wd[7:0]}};
      SZ_H:    d = {2{wd[15:0]}};
      SZ_W:    d = wd;
      default: d = 32'd0;
    endcase
    return d;
  endfunction

  // Misaligned halves/words are not trapped: the low address bits are simply ignored.
  function automatic logic [31:0] f_load_extract(input logic [2:0] size, input logic [1:0] off,
                                                 input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      SZ_B:    r = {{24{b[7]}}, b};
      SZ_BU:   r = {24'd0, b};
      SZ_H:    r = {{16{h[15]}}, h};
      SZ_HU:   r = {16'd0, h};
      SZ_W:    r = rd;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reset gates the handshake outputs combinationally so an in-flight access dies at once.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_mem_req   = 1'b0;
    w_stall     = 1'b0;
    if (!rst_i && core_req_i) begin
      w_mem_req = 1'b1;
      case (r_state)
        S_IDLE: begin
          w_stall     = 1'b1;
          w_state_nxt = S_BUSY;
        end
        S_BUSY: begin
          w_stall     = !mem_ready_i;
          w_state_nxt = mem_ready_i ? S_IDLE : S_BUSY;
        end
        default: begin
          w_stall     = 1'b0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o    = w_mem_req;
  assign core_stall_o = w_stall;
  assign mem_we_o     = w_mem_req & core_we_i;
  assign mem_addr_o   = core_addr_i;
  assign mem_be_o     = core_we_i ? f_store_be(core_size_i, core_addr_i[1:0]) : 4'b0000;
  assign mem_wd_o     = f_store_data(core_size_i, core_wd_i);
  assign core_rd_o    = f_load_extract(core_size_i, core_addr_i[1:0], mem_rd_i);

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed vector table, hand-written handshake sequences
// and a randomized run against an arithmetic reference model.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int checks = 0;
  int errors = 0;

  riscv_lsu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wdo;
    logic [31:0] rdo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain shifts and arithmetic on the lane rules.
  function automatic logic [31:0] ref_rd(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int unsigned sh;
    case (size)
      3'd0, 3'd4: begin
        sh = 8 * int'(addr % 4);
        v  = (rd >> sh) & 32'hFF;
        if (size == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        sh = 16 * int'((addr / 2) % 2);
        v  = (rd >> sh) & 32'hFFFF;
        if (size == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      3'd2:    v = rd;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic we, input logic [2:0] size,
                                        input logic [31:0] addr);
    int unsigned m;
    if (!we) return 4'b0000;
    case (size)
      3'd0:    m = 1 << (addr % 4);
      3'd1:    m = 3 << (2 * ((addr / 2) % 2));
      3'd2:    m = 15;
      default: m = 0;
    endcase
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wd(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'd0:    return (wd & 32'hFF) * 32'h01010101;
      3'd1:    return (wd & 32'hFFFF) * 32'h00010001;
      3'd2:    return wd;
      default: return 32'd0;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic rdy);
    core_req_i  = req;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_rd_i    = rd;
    mem_ready_i = rdy;
    #1;
  endtask

  vec_t tbl[$];
  int   age;
  logic exp_stall;
  logic [2:0] sizes[8];

  initial begin
    tbl.push_back('{"LB_0x103",  1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0102, 4'h0, 32'h0,        32'hFFFFFF80});
    tbl.push_back('{"LBU_0x103", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0102, 4'h0, 32'h0,        32'h00000080});
    tbl.push_back('{"LH_0x102",  1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF0102, 4'h0, 32'h0,        32'hFFFF80FF});
    tbl.push_back('{"LHU_0x102", 1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF0102, 4'h0, 32'h0,        32'h000080FF});
    tbl.push_back('{"LH_0x101",  1'b0, 3'd1, 32'h101, 32'h0, 32'h80FF8102, 4'h0, 32'h0,        32'hFFFF8102});
    tbl.push_back('{"LB_0x101",  1'b0, 3'd0, 32'h101, 32'h0, 32'h80FF7F02, 4'h0, 32'h0,        32'h0000007F});
    tbl.push_back('{"LW_0x103",  1'b0, 3'd2, 32'h103, 32'h0, 32'hDEADBEEF, 4'h0, 32'h0,        32'hDEADBEEF});
    tbl.push_back('{"L_size3",   1'b0, 3'd3, 32'h100, 32'h0, 32'hDEADBEEF, 4'h0, 32'h0,        32'h0});
    tbl.push_back('{"SB_0x201",  1'b1, 3'd0, 32'h201, 32'h12345678, 32'h0, 4'b0010, 32'h78787878, 32'h0});
    tbl.push_back('{"SH_0x202",  1'b1, 3'd1, 32'h202, 32'h12345678, 32'h0, 4'b1100, 32'h56785678, 32'h0});
    tbl.push_back('{"SH_0x203",  1'b1, 3'd1, 32'h203, 32'h12345678, 32'h0, 4'b1100, 32'h56785678, 32'h0});
    tbl.push_back('{"SW_0x200",  1'b1, 3'd2, 32'h200, 32'h12345678, 32'h0, 4'b1111, 32'h12345678, 32'h0});
    tbl.push_back('{"S_size6",   1'b1, 3'd6, 32'h200, 32'h12345678, 32'h0, 4'b0000, 32'h0,        32'h0});

    // Reset with a pending request: handshake outputs stay low.
    rst_i = 1'b1;
    drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1);
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
    next_cycle();
    chk("rst_mem_req_clk", {31'd0, mem_req_o}, 32'd0);
    drive(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1);
    rst_i = 1'b0;
    next_cycle();

    // Combinational lane vectors, FSM idle.
    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wd, tbl[i].rd, 1'b0);
      chk({tbl[i].name, "_be"}, {28'd0, mem_be_o}, {28'd0, tbl[i].be});
      if (tbl[i].we) chk({tbl[i].name, "_wd"}, mem_wd_o, tbl[i].wdo);
      else           chk({tbl[i].name, "_rd"}, core_rd_o, tbl[i].rdo);
      chk({tbl[i].name, "_idle_req"}, {31'd0, mem_req_o}, 32'd0);
    end
    next_cycle();

    // LW with memory always ready: two-cycle access.
    drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1);
    chk("lw_c0_stall", {31'd0, core_stall_o}, 32'd1);
    chk("lw_c0_req", {31'd0, mem_req_o}, 32'd1);
    chk("lw_addr", mem_addr_o, 32'h100);
    next_cycle();
    chk("lw_c1_stall", {31'd0, core_stall_o}, 32'd0);
    chk("lw_c1_rd", core_rd_o, 32'hDEADBEEF);
    chk("lw_be", {28'd0, mem_be_o}, 32'd0);
    chk("lw_we", {31'd0, mem_we_o}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1);
    next_cycle();

    // Store with wait states: stall high four cycles, request held throughout.
    drive(1'b1, 1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("ws_stall_c%0d", c), {31'd0, core_stall_o}, 32'd1);
      chk($sformatf("ws_req_c%0d", c), {31'd0, mem_req_o}, 32'd1);
      chk($sformatf("ws_we_c%0d", c), {31'd0, mem_we_o}, 32'd1);
      next_cycle();
    end
    mem_ready_i = 1'b1;
    #1;
    chk("ws_stall_ready", {31'd0, core_stall_o}, 32'd0);
    chk("ws_req_ready", {31'd0, mem_req_o}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b0);
    next_cycle();

    // Reset pulsed mid-BUSY aborts at once; the next LW takes two cycles.
    drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h11223344, 1'b0);
    next_cycle();
    chk("rb_busy_stall", {31'd0, core_stall_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rb_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("rb_stall_drop", {31'd0, core_stall_o}, 32'd0);
    core_req_i = 1'b0;
    #1;
    rst_i = 1'b0;
    next_cycle();
    drive(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'h11223344, 1'b1);
    chk("rb_lw_c0_stall", {31'd0, core_stall_o}, 32'd1);
    next_cycle();
    chk("rb_lw_c1_stall", {31'd0, core_stall_o}, 32'd0);
    chk("rb_lw_c1_rd", core_rd_o, 32'h11223344);
    next_cycle();

    // Back-to-back LW with request held: stall pattern 1,0,1,0 (this cycle is cycle 0).
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("b2b_stall_c%0d", c), {31'd0, core_stall_o}, (c % 2 == 0) ? 32'd1 : 32'd0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b1);
    next_cycle();

    // Abort in BUSY: request dropped, FSM back in IDLE the next cycle.
    drive(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b0);
    next_cycle();
    core_req_i = 1'b0;
    #1;
    chk("ab_req", {31'd0, mem_req_o}, 32'd0);
    chk("ab_stall", {31'd0, core_stall_o}, 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1);
    chk("ab_idle_again_stall", {31'd0, core_stall_o}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b0);
    next_cycle();

    // Randomized run against the reference model; age counts cycles spent in an access.
    sizes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    age = 0;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom()), sizes[$urandom_range(0, 7)],
            $urandom(), $urandom(), $urandom(), ($urandom_range(0, 2) != 0));
      exp_stall = core_req_i && !(age > 0 && mem_ready_i);
      chk("rnd_req", {31'd0, mem_req_o}, {31'd0, core_req_i});
      chk("rnd_stall", {31'd0, core_stall_o}, {31'd0, exp_stall});
      chk("rnd_we", {31'd0, mem_we_o}, {31'd0, core_req_i & core_we_i});
      chk("rnd_addr", mem_addr_o, core_addr_i);
      chk("rnd_be", {28'd0, mem_be_o}, {28'd0, ref_be(core_we_i, core_size_i, core_addr_i)});
      chk("rnd_wd", mem_wd_o, ref_wd(core_size_i, core_wd_i));
      chk("rnd_rd", core_rd_o, ref_rd(core_size_i, core_addr_i, mem_rd_i));
      age = exp_stall ? age + 1 : 0;
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset:
  clk_i        in   1   clock; all state updates on rising edge
  rst_i        in   1   asynchronous, active-high reset
REQ-002 SHALL have these core-side ports, fed by the instruction decoder and datapath:
  core_req_i   in   1   memory access requested (decoder mem_req)
  core_we_i    in   1   1=store, 0=load (decoder mem_we)
  core_size_i  in   3   0=B, 1=H, 2=W, 4=BU, 5=HU (decoder mem_size)
  core_addr_i  in   32  byte address (ALU result)
  core_wd_i    in   32  store data (rs2)
  core_rd_o    out  32  load result, extended to 32 bits
  core_stall_o out  1   1 = freeze PC and register-file write
REQ-003 SHALL have these memory-side ports:
  mem_req_o    out  1   request to data memory
  mem_we_o     out  1   write enable
  mem_be_o     out  4   byte enables
  mem_addr_o   out  32  address
  mem_wd_o     out  32  write data
  mem_rd_i     in   32  read word
  mem_ready_i  in   1   memory completes the current access

Function
REQ-004 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-005 IDLE, core_req_i=1: mem_req_o=1, core_stall_o=1 (even if mem_ready_i=1); next state BUSY.
REQ-006 IDLE, core_req_i=0: mem_req_o=0, core_stall_o=0; stay IDLE.
REQ-007 BUSY, core_req_i=1, mem_ready_i=0: mem_req_o=1, core_stall_o=1; stay BUSY.
REQ-008 BUSY, core_req_i=1, mem_ready_i=1: mem_req_o=1, core_stall_o=0, core_rd_o valid this cycle; next state IDLE.
REQ-009 BUSY, core_req_i=0 (aborted request): mem_req_o=0, core_stall_o=0; next state IDLE.
REQ-010 Minimum access latency SHALL be 2 cycles; back-to-back accesses SHALL each re-enter BUSY via IDLE.
REQ-011 mem_we_o=core_we_i, mem_addr_o=core_addr_i (unmodified), driven combinationally whenever mem_req_o=1; mem_we_o=0 when mem_req_o=0.
REQ-012 Store byte enables: size 0 -> 4'b0001<<addr[1:0]; size 1 -> addr[1]?4'b1100:4'b0011; size 2 -> 4'b1111; any other size or load -> 4'b0000.
REQ-013 Store data: size 0 -> {4{wd[7:0]}}; size 1 -> {2{wd[15:0]}}; size 2 -> wd; other -> 0.
REQ-014 Load extraction, off=addr[1:0]: B -> sign-ext mem_rd_i[8*off+:8]; BU -> zero-ext same byte; H -> sign-ext mem_rd_i[16*addr[1]+:16]; HU -> zero-ext same half; W -> mem_rd_i.
REQ-015 Misalignment SHALL NOT be detected: H/HU ignore addr[0]; W ignores addr[1:0].
REQ-016 Unsupported size (3,6,7): core_rd_o=0, mem_be_o=0; FSM timing unchanged.
REQ-017 core_rd_o is combinational from mem_rd_i and registered-free; it is valid only in the REQ-008 cycle and otherwise SHALL still follow REQ-014.
REQ-018 The core SHALL hold core_* inputs stable while core_stall_o=1; the LSU does not latch them.

Reset
REQ-019 While rst_i=1, the FSM SHALL be IDLE asynchronously; mem_req_o=0, core_stall_o=0.
REQ-020 Reset asserted in BUSY SHALL abort the access immediately; after release the first core_req_i starts a fresh access (REQ-005).
REQ-021 No other state SHALL exist; all other outputs are combinational from inputs.

Verification
REQ-022 LW: addr=0x100, mem_rd_i=0xDEADBEEF, ready=1 always -> stall=1 cycle 0, stall=0 cycle 1, core_rd_o=0xDEADBEEF, be=0000, we=0.
REQ-023 LB/LBU: addr=0x103, mem_rd_i=0x80FF_0102 -> LB core_rd_o=0xFFFFFF80, LBU 0x00000080; LH addr=0x102 -> 0xFFFF80FF.
REQ-024 SB addr=0x201 wd=0x12345678 -> be=0010, mem_wd_o=0x78787878; SH addr=0x202 -> be=1100, wd=0x56785678; SW -> be=1111.
REQ-025 Wait states: ready=0 for 3 cycles after request -> stall high 4 cycles total, falls the cycle ready=1; mem_req_o held throughout.
REQ-026 rst_i pulsed mid-BUSY -> mem_req_o and core_stall_o drop the same cycle; next LW completes in 2 cycles.
REQ-027 Two consecutive LW with ready=1 -> stall pattern 1,0,1,0; core_req_i dropped in BUSY -> mem_req_o=0 and IDLE next cycle.
